// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IF fetches and MEM-stage data accesses onto one fixed-latency memory.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; the default build uses fixed DM priority.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic              o_if_done,
   output logic [DATA_W-1:0] o_if_rdata,
   output logic              o_if_stall,
   input  logic              i_dm_req,
   input  logic              i_dm_we,
   input  logic [ADDR_W-1:0] i_dm_addr,
   input  logic [DATA_W-1:0] i_dm_wdata,
   output logic              o_dm_done,
   output logic [DATA_W-1:0] o_dm_rdata,
   output logic              o_dm_stall,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_busy,
   output logic [1:0]        o_dbg_state
);

   localparam int               CNT_W    = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
   localparam logic             OWN_IF   = 1'b0;
   localparam logic             OWN_DM   = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_owner;
   logic              r_store;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_if_done;
   logic              r_dm_done;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_dm_rdata;
   logic              r_busy;
   logic              w_any_req;
   logic              w_grant_dm;
   logic              w_take;
   logic              w_last_beat;

   assign w_any_req = i_if_req | i_dm_req;

`ifdef MEM_ARB_RR_EN
   logic r_last;

   // On a tie the port that did not own the previous access wins.
   assign w_grant_dm = i_dm_req & (~i_if_req | (r_last == OWN_IF));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last <= OWN_IF;
      end else if (w_take) begin
         r_last <= w_grant_dm;
      end
   end
`else
   assign w_grant_dm = i_dm_req;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_last_beat = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               w_take      = 1'b1;
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: w_state_nxt = WAIT;
         WAIT: begin
            if (r_cnt == CNT_LAST) begin
               w_last_beat = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_owner     <= OWN_IF;
         r_store     <= 1'b0;
         r_cnt       <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_done   <= 1'b0;
         r_dm_done   <= 1'b0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_mem_en  <= w_take;
         r_mem_we  <= w_take & w_grant_dm & i_dm_we;
         r_if_done <= w_last_beat & (r_owner == OWN_IF);
         r_dm_done <= w_last_beat & (r_owner == OWN_DM);
         r_busy    <= (w_state_nxt != IDLE);

         if (w_take) begin
            r_owner    <= w_grant_dm;
            r_store    <= w_grant_dm & i_dm_we;
            r_mem_addr <= w_grant_dm ? i_dm_addr : i_if_addr;
            if (w_grant_dm) begin
               r_mem_wdata <= i_dm_wdata;
            end
         end

         if (r_state == ISSUE) begin
            r_cnt <= '0;
         end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end

         // Stores leave dm_rdata untouched; the memory bus carries garbage for them.
         if (w_last_beat) begin
            if (r_owner == OWN_IF) begin
               r_if_rdata <= i_mem_rdata;
            end else if (!r_store) begin
               r_dm_rdata <= i_mem_rdata;
            end
         end
      end
   end

   assign o_if_done   = r_if_done;
   assign o_if_rdata  = r_if_rdata;
   assign o_if_stall  = i_if_req & ~r_if_done;
   assign o_dm_done   = r_dm_done;
   assign o_dm_rdata  = r_dm_rdata;
   assign o_dm_stall  = i_dm_req & ~r_dm_done;
   assign o_mem_en    = r_mem_en;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_busy      = r_busy;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: three arbiters (MEM_LAT 1, 2, 4) driven in lockstep and checked every cycle
// against a transaction-level timeline model plus directed timing checks.
module tb_mem_arbiter;

   localparam int NL = 3;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req    [NL];
   logic [AW-1:0] if_addr   [NL];
   logic          if_done   [NL];
   logic [DW-1:0] if_rdata  [NL];
   logic          if_stall  [NL];
   logic          dm_req    [NL];
   logic          dm_we     [NL];
   logic [AW-1:0] dm_addr   [NL];
   logic [DW-1:0] dm_wdata  [NL];
   logic          dm_done   [NL];
   logic [DW-1:0] dm_rdata  [NL];
   logic          dm_stall  [NL];
   logic          mem_en    [NL];
   logic          mem_we    [NL];
   logic [AW-1:0] mem_addr  [NL];
   logic [DW-1:0] mem_wdata [NL];
   logic [DW-1:0] mem_rdata [NL];
   logic          busy      [NL];
   logic [1:0]    dbg_state [NL];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NL; g++) begin : g_dut
      mem_arbiter #(
         .ADDR_W (AW),
         .DATA_W (DW),
         .MEM_LAT(g == 0 ? 1 : (g == 1 ? 2 : 4))
      ) u_dut (
         .i_clk      (clk),
         .i_rst_n    (rst_n),
         .i_if_req   (if_req[g]),
         .i_if_addr  (if_addr[g]),
         .o_if_done  (if_done[g]),
         .o_if_rdata (if_rdata[g]),
         .o_if_stall (if_stall[g]),
         .i_dm_req   (dm_req[g]),
         .i_dm_we    (dm_we[g]),
         .i_dm_addr  (dm_addr[g]),
         .i_dm_wdata (dm_wdata[g]),
         .o_dm_done  (dm_done[g]),
         .o_dm_rdata (dm_rdata[g]),
         .o_dm_stall (dm_stall[g]),
         .o_mem_en   (mem_en[g]),
         .o_mem_we   (mem_we[g]),
         .o_mem_addr (mem_addr[g]),
         .o_mem_wdata(mem_wdata[g]),
         .i_mem_rdata(mem_rdata[g]),
         .o_busy     (busy[g]),
         .o_dbg_state(dbg_state[g])
      );
   end

   int          cyc;
   int          n_tests;
   int          n_fail;
   // timeline model: one access at a time, fixed occupancy per access
   int          free_at   [NL];
   int          en_cyc    [NL];
   int          done_cyc  [NL];
   bit          own_dm    [NL];
   bit          t_we      [NL];
   logic [31:0] t_addr    [NL];
   logic [31:0] t_wdata   [NL];
   logic [31:0] t_rdata   [NL];
   logic [31:0] exp_if_rd [NL];
   logic [31:0] exp_dm_rd [NL];
   bit          last_dm   [NL];
   logic [31:0] ref_mem   [NL][256];
   // memory environment
   logic [31:0] env_mem   [NL][256];
   int          env_rd_cyc[NL];
   logic [31:0] env_rd_data[NL];
   // requesters (port 0 = IF, 1 = DM)
   bit          p_busy    [NL][2];
   bit          p_granted [NL][2];
   int          p_en      [NL][2];
   int          p_done    [NL][2];
   int          p_gap     [NL][2];
   bit          auto_new;
   bit          hold_mode;
   bit          drop_en;

   function automatic int lat_of(input int l);
      return (l == 0) ? 1 : ((l == 1) ? 2 : 4);
   endfunction

   function automatic logic [31:0] mem_init(input int ix);
      return 32'h5A00_0000 + 32'(ix);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_tests++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, want);
      end
   endtask

   task automatic set_req(input int l, input int p, input logic v);
      if (p == 0) if_req[l] = v;
      else        dm_req[l] = v;
   endtask

   task automatic post(input int l, input int p, input logic [31:0] a, input logic we,
                       input logic [31:0] wd);
      p_busy[l][p]    = 1'b1;
      p_granted[l][p] = 1'b0;
      if (p == 0) begin
         if_addr[l] = a;
         if_req[l]  = 1'b1;
      end else begin
         dm_addr[l]  = a;
         dm_we[l]    = we;
         dm_wdata[l] = wd;
         dm_req[l]   = 1'b1;
      end
   endtask

   task automatic post_rand(input int l, input int p);
      logic [31:0] a;
      a = 32'($urandom_range(0, 15)) << 2;
      post(l, p, a, (p == 1) && ($urandom_range(0, 2) == 0), $urandom);
   endtask

   task automatic model_reset();
      for (int l = 0; l < NL; l++) begin
         free_at[l]    = cyc + 1;
         en_cyc[l]     = -100;
         done_cyc[l]   = -100;
         exp_if_rd[l]  = '0;
         exp_dm_rd[l]  = '0;
         last_dm[l]    = 1'b0;
         env_rd_cyc[l] = -100;
         if_req[l]     = 1'b0;
         dm_req[l]     = 1'b0;
         for (int p = 0; p < 2; p++) begin
            p_busy[l][p]    = 1'b0;
            p_granted[l][p] = 1'b0;
            p_gap[l][p]     = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      for (int l = 0; l < NL; l++) begin
         mem_rdata[l] = (cyc == env_rd_cyc[l]) ? env_rd_data[l] : $urandom;
      end
   endtask

   task automatic drive();
      for (int l = 0; l < NL; l++) begin
         for (int p = 0; p < 2; p++) begin
            if (p_busy[l][p] && p_granted[l][p] && cyc == p_done[l][p] + 1) begin
               p_busy[l][p] = 1'b0;
               set_req(l, p, 1'b0);
               p_gap[l][p] = hold_mode ? 0 : $urandom_range(0, 4);
            end
            if (drop_en && p_busy[l][p] && p_granted[l][p] && cyc > p_en[l][p] &&
                $urandom_range(0, 9) == 0) begin
               set_req(l, p, 1'b0);
            end
            if (!p_busy[l][p] && auto_new) begin
               if (p_gap[l][p] == 0) post_rand(l, p);
               else p_gap[l][p]--;
            end
         end
      end
   endtask

   task automatic model_check();
      bit dm;
      bit e_en;
      bit e_ifd;
      bit e_dmd;
      int ix;
      for (int l = 0; l < NL; l++) begin
         if (cyc >= free_at[l] && (if_req[l] || dm_req[l])) begin
`ifdef MEM_ARB_RR_EN
            dm = dm_req[l] && (!if_req[l] || !last_dm[l]);
            last_dm[l] = dm;
`else
            dm = dm_req[l];
`endif
            own_dm[l]   = dm;
            t_we[l]     = dm && dm_we[l];
            t_addr[l]   = dm ? dm_addr[l] : if_addr[l];
            t_wdata[l]  = dm_wdata[l];
            en_cyc[l]   = cyc + 1;
            done_cyc[l] = cyc + 2 + lat_of(l);
            free_at[l]  = cyc + 3 + lat_of(l);
            ix = int'(t_addr[l][9:2]);
            if (t_we[l]) ref_mem[l][ix] = t_wdata[l];
            else t_rdata[l] = ref_mem[l][ix];
            p_granted[l][int'(dm)] = 1'b1;
            p_en[l][int'(dm)]      = en_cyc[l];
            p_done[l][int'(dm)]    = done_cyc[l];
         end
      end
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
         e_en  = (cyc == en_cyc[l]);
         e_ifd = (cyc == done_cyc[l]) && !own_dm[l];
         e_dmd = (cyc == done_cyc[l]) && own_dm[l];
         if (e_ifd) exp_if_rd[l] = t_rdata[l];
         if (e_dmd && !t_we[l]) exp_dm_rd[l] = t_rdata[l];
         chk($sformatf("l%0d mem_en", l), 32'(mem_en[l]), 32'(e_en));
         chk($sformatf("l%0d mem_we", l), 32'(mem_we[l]), 32'(e_en && t_we[l]));
         if (e_en) chk($sformatf("l%0d mem_addr", l), mem_addr[l], t_addr[l]);
         if (e_en && t_we[l]) chk($sformatf("l%0d mem_wdata", l), mem_wdata[l], t_wdata[l]);
         chk($sformatf("l%0d if_done", l), 32'(if_done[l]), 32'(e_ifd));
         chk($sformatf("l%0d dm_done", l), 32'(dm_done[l]), 32'(e_dmd));
         chk($sformatf("l%0d if_rdata", l), if_rdata[l], exp_if_rd[l]);
         chk($sformatf("l%0d dm_rdata", l), dm_rdata[l], exp_dm_rd[l]);
         chk($sformatf("l%0d if_stall", l), 32'(if_stall[l]), 32'(if_req[l] && !e_ifd));
         chk($sformatf("l%0d dm_stall", l), 32'(dm_stall[l]), 32'(dm_req[l] && !e_dmd));
         chk($sformatf("l%0d busy", l), 32'(busy[l]),
             32'(cyc >= en_cyc[l] && cyc <= done_cyc[l]));
         if (mem_en[l] === 1'b1) begin
            ix = int'(mem_addr[l][9:2]);
            if (mem_we[l]) begin
               env_mem[l][ix] = mem_wdata[l];
            end else begin
               env_rd_cyc[l]  = cyc + lat_of(l);
               env_rd_data[l] = env_mem[l][ix];
            end
         end
      end
   endtask

   task automatic cycle_start();
      tick();
      drive();
   endtask

   task automatic step();
      cycle_start();
      model_check();
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic chk_idle_outputs(input string tag);
      for (int l = 0; l < NL; l++) begin
         chk($sformatf("%s l%0d mem_en", tag, l), 32'(mem_en[l]), 32'd0);
         chk($sformatf("%s l%0d mem_we", tag, l), 32'(mem_we[l]), 32'd0);
         chk($sformatf("%s l%0d busy", tag, l), 32'(busy[l]), 32'd0);
         chk($sformatf("%s l%0d if_done", tag, l), 32'(if_done[l]), 32'd0);
         chk($sformatf("%s l%0d dm_done", tag, l), 32'(dm_done[l]), 32'd0);
         chk($sformatf("%s l%0d if_rdata", tag, l), if_rdata[l], 32'd0);
         chk($sformatf("%s l%0d dm_rdata", tag, l), dm_rdata[l], 32'd0);
         chk($sformatf("%s l%0d mem_addr", tag, l), mem_addr[l], 32'd0);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int t0;
      int ifc;
      int dmc;
      n_tests   = 0;
      n_fail    = 0;
      cyc       = -1;
      auto_new  = 1'b0;
      hold_mode = 1'b0;
      drop_en   = 1'b0;
      rst_n     = 1'b0;
      for (int l = 0; l < NL; l++) begin
         if_addr[l]   = '0;
         dm_we[l]     = 1'b0;
         dm_addr[l]   = '0;
         dm_wdata[l]  = '0;
         mem_rdata[l] = '0;
         for (int i = 0; i < 256; i++) begin
            ref_mem[l][i] = mem_init(i);
            env_mem[l][i] = mem_init(i);
         end
         ref_mem[l][16] = 32'hDEAD_BEEF;
         env_mem[l][16] = 32'hDEAD_BEEF;
      end
      model_reset();

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk_idle_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // simultaneous requests: DM first, IF after the dead cycle
      t0 = cyc + 1;
      cycle_start();
      for (int l = 0; l < NL; l++) begin
         post(l, 1, 32'h48, 1'b0, 32'h0);
         post(l, 0, 32'h44, 1'b0, 32'h0);
      end
      model_check();
      chk("tie if_stall@0", 32'(if_stall[1]), 32'd1);
      wait_to(t0 + 4);
      chk("tie dm_done@4", 32'(dm_done[1]), 32'd1);
      chk("tie dm_rdata@4", dm_rdata[1], mem_init(18));
      wait_to(t0 + 5);
      chk("tie if_stall@5", 32'(if_stall[1]), 32'd1);
      wait_to(t0 + 6);
      chk("tie if mem_en@6", 32'(mem_en[1]), 32'd1);
      chk("tie if mem_addr@6", mem_addr[1], 32'h44);
      wait_to(t0 + 9);
      chk("tie if_done@9", 32'(if_done[1]), 32'd1);
      chk("tie if_rdata@9", if_rdata[1], mem_init(17));
      wait_to(t0 + 16);

      // single fetch
      t0 = cyc + 1;
      cycle_start();
      for (int l = 0; l < NL; l++) post(l, 0, 32'h40, 1'b0, 32'h0);
      model_check();
      chk("fetch if_stall@0", 32'(if_stall[1]), 32'd1);
      wait_to(t0 + 1);
      chk("fetch mem_en@1", 32'(mem_en[1]), 32'd1);
      chk("fetch mem_addr@1", mem_addr[1], 32'h40);
      wait_to(t0 + 3);
      chk("fetch if_stall@3", 32'(if_stall[1]), 32'd1);
      wait_to(t0 + 4);
      chk("fetch if_done@4", 32'(if_done[1]), 32'd1);
      chk("fetch if_rdata@4", if_rdata[1], 32'hDEAD_BEEF);
      chk("fetch if_stall@4", 32'(if_stall[1]), 32'd0);
      wait_to(t0 + 10);

      // store, then load it back
      t0 = cyc + 1;
      cycle_start();
      for (int l = 0; l < NL; l++) post(l, 1, 32'h100, 1'b1, 32'h1234);
      model_check();
      wait_to(t0 + 1);
      chk("store mem_en@1", 32'(mem_en[1]), 32'd1);
      chk("store mem_we@1", 32'(mem_we[1]), 32'd1);
      chk("store mem_wdata@1", mem_wdata[1], 32'h1234);
      chk("store mem_addr@1", mem_addr[1], 32'h100);
      wait_to(t0 + 4);
      chk("store dm_done@4", 32'(dm_done[1]), 32'd1);
      chk("store dm_rdata kept", dm_rdata[1], mem_init(18));
      wait_to(t0 + 10);
      t0 = cyc + 1;
      cycle_start();
      for (int l = 0; l < NL; l++) post(l, 1, 32'h100, 1'b0, 32'h0);
      model_check();
      wait_to(t0 + 4);
      chk("reload dm_rdata@4", dm_rdata[1], 32'h1234);
      wait_to(t0 + 10);

      // both ports requesting continuously
      for (int l = 0; l < NL; l++) begin
         p_gap[l][0] = 0;
         p_gap[l][1] = 0;
      end
      auto_new  = 1'b1;
      hold_mode = 1'b1;
      ifc = 0;
      dmc = 0;
      repeat (40) begin
         step();
         ifc += int'(if_done[1]);
         dmc += int'(dm_done[1]);
      end
`ifdef MEM_ARB_RR_EN
      chk("hold if grants", 32'(ifc), 32'd4);
      chk("hold dm grants", 32'(dmc), 32'd4);
`else
      chk("hold if grants", 32'(ifc), 32'd0);
      chk("hold dm grants", 32'(dmc), 32'd8);
`endif
      auto_new  = 1'b0;
      hold_mode = 1'b0;
      wait_to(cyc + 30);

      // reset during WAIT abandons the access
      t0 = cyc + 1;
      cycle_start();
      for (int l = 0; l < NL; l++) post(l, 0, 32'h40, 1'b0, 32'h0);
      model_check();
      step();
      tick();
      chk("pre-reset busy", 32'(busy[1]), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_idle_outputs("async reset");
      for (int l = 0; l < NL; l++) begin
         if_req[l] = 1'b0;
         dm_req[l] = 1'b0;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      wait_to(cyc + 8);
      t0 = cyc + 1;
      cycle_start();
      for (int l = 0; l < NL; l++) post(l, 0, 32'h44, 1'b0, 32'h0);
      model_check();
      wait_to(t0 + 3);
      chk("post-reset if_done@3", 32'(if_done[1]), 32'd0);
      wait_to(t0 + 4);
      chk("post-reset if_done@4", 32'(if_done[1]), 32'd1);
      chk("post-reset if_rdata@4", if_rdata[1], mem_init(17));
      wait_to(t0 + 10);

      // randomized traffic with mid-access request drops
      auto_new = 1'b1;
      drop_en  = 1'b1;
      repeat (1500) step();
      auto_new = 1'b0;
      drop_en  = 1'b0;
      repeat (40) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
